// File: rtl/axis_s_pkt.sv
// AXI-Stream slave ingress buffer: FWFT storage with occupancy/packet counts and an
// optional store-and-forward mode whose oversized packets fall back to cut-through.
module axis_s_pkt #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 8,
   parameter int PKT_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   input  logic                       ready,
   output logic                       valid_out,
   output logic [WIDTH-1:0]           data_out,
   output logic                       last_out,
   output logic [$clog2(DEPTH):0]     level,
   output logic [$clog2(DEPTH):0]     pkt_count,
   output logic                       cut_through
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [LW-1:0] ONE  = LW'(1);

   logic [WIDTH:0]  mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   level_q;
   logic [LW-1:0]   pkt_q;
   logic            ct_q;
   logic [WIDTH:0]  head;
   logic            push;
   logic            pop;
   logic            push_last;
   logic            pop_last;
   logic            ct_set;

   assign head          = mem[rd_ptr];
   assign data_out      = head[WIDTH-1:0];
   assign last_out      = head[WIDTH];
   assign s_axis_tready = (level_q != FULL);
   // Stream mode ignores packet boundaries; packet mode waits for a whole packet
   // unless the fallback is active.
   assign valid_out     = (level_q != '0) &&
                          ((PKT_MODE == 0) || (pkt_q != '0) || ct_q);
   assign push          = s_axis_tvalid & s_axis_tready;
   assign pop           = ready & valid_out;
   assign push_last     = push & s_axis_tlast;
   assign pop_last      = pop & last_out;
   assign ct_set        = (level_q == FULL) && (pkt_q == '0);
   assign level         = level_q;
   assign pkt_count     = pkt_q;
   assign cut_through   = ct_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         pkt_q   <= '0;
         ct_q    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);

         case ({push, pop})
            2'b10:   level_q <= level_q + ONE;
            2'b01:   level_q <= level_q - ONE;
            default: level_q <= level_q;
         endcase

         case ({push_last, pop_last})
            2'b10:   pkt_q <= pkt_q + ONE;
            2'b01:   pkt_q <= pkt_q - ONE;
            default: pkt_q <= pkt_q;
         endcase

         // A full buffer with no complete packet could never drain otherwise.
         if (PKT_MODE == 0)  ct_q <= 1'b0;
         else if (pop_last)  ct_q <= 1'b0;
         else if (ct_set)    ct_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_s_pkt.sv
// Bench for axis_s_pkt: a stream-mode DEPTH=8 and a packet-mode DEPTH=4 instance
// share stimulus and are both checked every cycle against a shift-array model.
module tb_axis_s_pkt;

   logic        clk = 1'b0;
   logic        rst;
   logic        tvalid;
   logic        tlast;
   logic        ready;
   logic [31:0] tdata;

   always #5 clk = ~clk;

   wire         rdy_s, vout_s, lout_s, ct_s;
   wire  [31:0] dout_s;
   wire  [3:0]  lvl_s, pc_s;
   wire         rdy_p, vout_p, lout_p, ct_p;
   wire  [31:0] dout_p;
   wire  [2:0]  lvl_p, pc_p;

   axis_s_pkt #(.WIDTH(32), .DEPTH(8), .PKT_MODE(0)) u_s (
      .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
      .s_axis_tready(rdy_s), .s_axis_tlast(tlast), .ready(ready),
      .valid_out(vout_s), .data_out(dout_s), .last_out(lout_s),
      .level(lvl_s), .pkt_count(pc_s), .cut_through(ct_s));

   axis_s_pkt #(.WIDTH(32), .DEPTH(4), .PKT_MODE(1)) u_p (
      .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
      .s_axis_tready(rdy_p), .s_axis_tlast(tlast), .ready(ready),
      .valid_out(vout_p), .data_out(dout_p), .last_out(lout_p),
      .level(lvl_p), .pkt_count(pc_p), .cut_through(ct_p));

   int          n_cmp = 0;
   int          n_err = 0;
   bit          armed = 0;

   // Model: per instance an array kept packed at index 0 (oldest beat first).
   int          mdepth [2] = '{8, 4};
   int          mmode  [2] = '{0, 1};
   logic [32:0] mbuf   [2][8];
   int          msz    [2] = '{0, 0};
   bit          mct    [2] = '{0, 0};
   bit          acc1;
   logic [31:0] popq1 [$];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pkts(int i);
      int n = 0;
      for (int k = 0; k < msz[i]; k++) if (mbuf[i][k][32]) n++;
      return n;
   endfunction

   function automatic bit mvalid(int i);
      return (msz[i] != 0) && (mmode[i] == 0 || pkts(i) != 0 || mct[i]);
   endfunction

   task automatic check_inst(int i);
      logic [63:0] o_rdy, o_v, o_d, o_l, o_lvl, o_pc, o_ct;
      if (i == 0) begin
         o_rdy = 64'(rdy_s); o_v = 64'(vout_s); o_d = 64'(dout_s); o_l = 64'(lout_s);
         o_lvl = 64'(lvl_s); o_pc = 64'(pc_s); o_ct = 64'(ct_s);
      end else begin
         o_rdy = 64'(rdy_p); o_v = 64'(vout_p); o_d = 64'(dout_p); o_l = 64'(lout_p);
         o_lvl = 64'(lvl_p); o_pc = 64'(pc_p); o_ct = 64'(ct_p);
      end
      chk($sformatf("tready%0d", i), o_rdy, 64'(msz[i] != mdepth[i]));
      chk($sformatf("valid%0d", i), o_v, 64'(mvalid(i)));
      chk($sformatf("level%0d", i), o_lvl, 64'(msz[i]));
      chk($sformatf("pkt_count%0d", i), o_pc, 64'(pkts(i)));
      chk($sformatf("cut_through%0d", i), o_ct, 64'(mct[i]));
      if (mvalid(i)) begin
         chk($sformatf("data%0d", i), o_d, 64'(mbuf[i][0][31:0]));
         chk($sformatf("last%0d", i), o_l, 64'(mbuf[i][0][32]));
      end
   endtask

   task automatic tick(bit r, bit v, logic [31:0] d, bit l, bit rd);
      bit psh [2];
      bit pp  [2];
      rst = r; tvalid = v; tdata = d; tlast = l; ready = rd;
      #1;
      if (armed) begin
         check_inst(0);
         check_inst(1);
      end
      for (int i = 0; i < 2; i++) begin
         psh[i] = v && (msz[i] != mdepth[i]);
         pp[i]  = rd && mvalid(i);
      end
      acc1 = psh[1] && !r;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (r) begin
            msz[i] = 0;
            mct[i] = 0;
         end else begin
            bit set_c, clr_c;
            set_c = (msz[i] == mdepth[i]) && (pkts(i) == 0);
            clr_c = pp[i] && mbuf[i][0][32];
            if (pp[i]) begin
               if (i == 1) popq1.push_back(mbuf[i][0][31:0]);
               for (int k = 0; k < 7; k++) mbuf[i][k] = mbuf[i][k+1];
               msz[i]--;
            end
            if (psh[i]) begin
               mbuf[i][msz[i]] = {l, d};
               msz[i]++;
            end
            if (mmode[i] == 1) mct[i] = clr_c ? 1'b0 : (set_c ? 1'b1 : mct[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      tick(1, 0, 32'h0, 0, 0);
      armed = 1;
   endtask

   initial begin
      int  guard;
      bit  ct_seen;
      rst = 1; tvalid = 0; tdata = '0; tlast = 0; ready = 0;
      @(negedge clk);
      do_reset();
      chk("rst_tready_s", 64'(rdy_s), 64'd1);
      chk("rst_valid_p", 64'(vout_p), 64'd0);

      // Stream ordering: six beats held, then released one per cycle.
      for (int k = 0; k < 6; k++) tick(0, 1, 32'(k), 0, 0);
      chk("lvl6_s", 64'(lvl_s), 64'd6);
      for (int k = 0; k < 7; k++) tick(0, 0, 32'h0, 0, 1);
      chk("drain_lvl_s", 64'(lvl_s), 64'd0);

      // Full behaviour: 9th beat blocked until one cycle after a pop.
      do_reset();
      for (int k = 0; k < 8; k++) tick(0, 1, 32'h10 + 32'(k), 0, 0);
      chk("full_tready_s", 64'(rdy_s), 64'd0);
      tick(0, 1, 32'h18, 0, 1);
      chk("after_pop_tready_s", 64'(rdy_s), 64'd1);
      tick(0, 1, 32'h18, 0, 0);
      chk("ninth_lvl_s", 64'(lvl_s), 64'd8);
      for (int k = 0; k < 9; k++) tick(0, 0, 32'h0, 0, 1);
      chk("ninth_drain_s", 64'(lvl_s), 64'd0);

      // Store-and-forward: nothing shown until the tlast beat is in.
      do_reset();
      tick(0, 1, 32'hA1, 0, 1);
      chk("pkt_wait1", 64'(vout_p), 64'd0);
      tick(0, 1, 32'hA2, 0, 1);
      chk("pkt_wait2", 64'(vout_p), 64'd0);
      tick(0, 1, 32'hA3, 1, 1);
      chk("pkt_ready", 64'(vout_p), 64'd1);
      chk("pkt_cnt1", 64'(pc_p), 64'd1);
      chk("pkt_head", 64'(dout_p), 64'hA1);
      for (int k = 0; k < 3; k++) tick(0, 0, 32'h0, 0, 1);
      chk("pkt_cnt0", 64'(pc_p), 64'd0);

      // Push-with-tlast coinciding with pop-with-last.
      do_reset();
      tick(0, 1, 32'hB1, 1, 0);
      tick(0, 1, 32'hC1, 1, 1);
      chk("simul_pc_p", 64'(pc_p), 64'd1);
      chk("simul_lvl_p", 64'(lvl_p), 64'd1);
      chk("simul_data_p", 64'(dout_p), 64'hC1);
      chk("simul_pc_s", 64'(pc_s), 64'd1);
      tick(0, 0, 32'h0, 0, 1);

      // Oversized packet on the DEPTH=4 packet instance.
      do_reset();
      popq1.delete();
      ct_seen = 0;
      for (int k = 0; k < 6; k++) begin
         guard = 0;
         do begin
            tick(0, 1, 32'h60 + 32'(k), k == 5, 1);
            if (ct_p) ct_seen = 1;
            guard++;
         end while (!acc1 && guard < 20);
         chk("send_timeout", 64'(guard < 20), 64'd1);
      end
      for (int k = 0; k < 6; k++) tick(0, 0, 32'h0, 0, 1);
      chk("ct_seen", 64'(ct_seen), 64'd1);
      chk("ct_clear", 64'(ct_p), 64'd0);
      chk("ct_count", 64'(popq1.size()), 64'd6);
      for (int k = 0; k < 6; k++)
         if (k < popq1.size()) chk($sformatf("ct_beat%0d", k), 64'(popq1[k]), 64'h60 + 64'(k));

      // Reset mid-packet, then a single-beat packet.
      for (int k = 0; k < 5; k++) tick(0, 1, 32'h70 + 32'(k), 0, 0);
      tick(1, 0, 32'h0, 0, 0);
      chk("mid_lvl_s", 64'(lvl_s), 64'd0);
      chk("mid_pc_s", 64'(pc_s), 64'd0);
      chk("mid_valid_s", 64'(vout_s), 64'd0);
      chk("mid_tready_s", 64'(rdy_s), 64'd1);
      chk("mid_lvl_p", 64'(lvl_p), 64'd0);
      chk("mid_pc_p", 64'(pc_p), 64'd0);
      chk("mid_valid_p", 64'(vout_p), 64'd0);
      chk("mid_tready_p", 64'(rdy_p), 64'd1);
      tick(0, 1, 32'h55, 1, 1);
      chk("one_data_s", 64'(dout_s), 64'h55);
      chk("one_valid_p", 64'(vout_p), 64'd1);
      chk("one_data_p", 64'(dout_p), 64'h55);
      chk("one_last_p", 64'(lout_p), 64'd1);
      tick(0, 0, 32'h0, 0, 1);
      chk("one_empty_p", 64'(lvl_p), 64'd0);

      // Randomised traffic with occasional resets.
      for (int n = 0; n < 600; n++)
         tick(($urandom % 97) == 0, ($urandom % 4) != 0, $urandom,
              ($urandom % 4) == 0, ($urandom % 3) != 0);
      for (int n = 0; n < 12; n++) tick(0, 0, 32'h0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
